// File: rtl/connect_count_accumulator_pkg.sv
// Shared definitions for the connect-count accumulator slice.
//   - Default widths for the tag, accumulator and result counters.
//   - RESULT_COUNT_WIDTH: width of the per-result component count (a term is 1<<count).
//   - cca_state_e: batch FSM encoding (CCA_IDLE / CCA_ACCUM / CCA_FULL).
// Optional feature macro used by the slice: CONNECT_ACCUM_OVERFLOW_DETECT_EN.
package connect_count_accumulator_pkg;

    localparam int EXTRA_DATA_WIDTH_DEF = 14;
    localparam int SUM_WIDTH_DEF        = 64;
    localparam int COUNT_WIDTH_DEF      = 32;
    localparam int RESULT_COUNT_WIDTH   = 6;

    typedef enum logic [1:0] {
        CCA_IDLE  = 2'd0,
        CCA_ACCUM = 2'd1,
        CCA_FULL  = 2'd2
    } cca_state_e;

endpackage

// File: rtl/connect_count_accumulator_if.sv
// Bus bundle between the compute stream / host side and the accumulator.
//   start, expectedCount      : batch request (sampled only while idle)
//   busy                      : accumulator is collecting or holding a batch
//   done, resultCount,
//   extraDataIn               : one compute result per cycle when done is high
//   resultValid, resultAck    : batch total handshake toward the host
//   resultSum, resultChecksum,
//   resultsReceived           : batch total, XOR of tags, accepted result count
//   strayResult, overflow     : sticky status flags
// slave modport is the accumulator side, master the producer/consumer side.
interface connect_count_accumulator_if
    import connect_count_accumulator_pkg::*;
#(
    parameter int EXTRA_DATA_WIDTH = EXTRA_DATA_WIDTH_DEF,
    parameter int SUM_WIDTH        = SUM_WIDTH_DEF,
    parameter int COUNT_WIDTH      = COUNT_WIDTH_DEF
);
    logic                          start;
    logic [COUNT_WIDTH-1:0]        expectedCount;
    logic                          busy;
    logic                          done;
    logic [RESULT_COUNT_WIDTH-1:0] resultCount;
    logic [EXTRA_DATA_WIDTH-1:0]   extraDataIn;
    logic                          resultValid;
    logic                          resultAck;
    logic [SUM_WIDTH-1:0]          resultSum;
    logic [EXTRA_DATA_WIDTH-1:0]   resultChecksum;
    logic [COUNT_WIDTH-1:0]        resultsReceived;
    logic                          strayResult;
    logic                          overflow;

    modport slave (
        input  start, expectedCount, done, resultCount, extraDataIn, resultAck,
        output busy, resultValid, resultSum, resultChecksum, resultsReceived,
               strayResult, overflow
    );

    modport master (
        output start, expectedCount, done, resultCount, extraDataIn, resultAck,
        input  busy, resultValid, resultSum, resultChecksum, resultsReceived,
               strayResult, overflow
    );
endinterface

// File: rtl/connect_count_accumulator_pow2_term_adder.sv
// pow2_term_adder: registers the decoded term 1<<n (input stage) and adds it
// to the running sum supplied by the caller (add stage, combinational here;
// the caller owns the sum register).
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture a new term this cycle
//   n_i       : exponent of the term
//   sum_i     : current running sum
//   sum_o     : sum_i + registered term, modulo 2^SUM_WIDTH
//   carry_o   : carry out of the MSB (only when CONNECT_ACCUM_OVERFLOW_DETECT_EN)
module pow2_term_adder
    import connect_count_accumulator_pkg::*;
#(
    parameter int SUM_WIDTH = SUM_WIDTH_DEF
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [RESULT_COUNT_WIDTH-1:0] n_i,
    input  logic [SUM_WIDTH-1:0]          sum_i,
    output logic [SUM_WIDTH-1:0]          sum_o
`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
    ,
    output logic                          carry_o
`endif
);
    localparam logic [SUM_WIDTH-1:0] TERM_ONE = {{(SUM_WIDTH-1){1'b0}}, 1'b1};

    logic [SUM_WIDTH-1:0] term_q;
    logic [SUM_WIDTH-1:0] term_d;

    // Term decode; holding the old term when idle keeps the adder input quiet.
    always_comb begin
        term_d = term_q;
        if (load_i) begin
            term_d = TERM_ONE << n_i;
        end else begin
            term_d = term_q;
        end
    end

    // Input-stage term register.
    always_ff @(posedge clk) begin
        if (rst) begin
            term_q <= {SUM_WIDTH{1'b0}};
        end else begin
            term_q <= term_d;
        end
    end

`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
    logic [SUM_WIDTH:0] wide_sum_s;

    // One extra bit exposes the carry out of the MSB.
    always_comb begin
        wide_sum_s = {1'b0, sum_i} + {1'b0, term_q};
        sum_o      = wide_sum_s[SUM_WIDTH-1:0];
        carry_o    = wide_sum_s[SUM_WIDTH];
    end
`else
    // Plain wrapping add.
    always_comb begin
        sum_o = sum_i + term_q;
    end
`endif

endmodule

// File: rtl/connect_count_accumulator.sv
// connect_count_accumulator: sums 2^resultCount over a batch of compute
// results, XORs their tags into a checksum, and hands the total to the host
// with a valid/ack handshake.
//   clk, rst : clock, synchronous active-high reset (abandons any batch)
//   bus      : connect_count_accumulator_if.slave (see interface header)
// Pipeline: done/resultCount/extraDataIn are registered (S1), then added (S2),
// so a result at cycle N is visible in resultSum at N+2.
// A result counts only if the FSM was in ACCUM both when it entered S1 and
// while it sits in S1; anything else is dropped and raises strayResult. This
// makes done coincident with start stray, and drops results arriving after the
// batch filled.
// Optional feature: CONNECT_ACCUM_OVERFLOW_DETECT_EN enables the sticky
// overflow flag; otherwise overflow is tied low.
module connect_count_accumulator
    import connect_count_accumulator_pkg::*;
#(
    parameter int EXTRA_DATA_WIDTH = EXTRA_DATA_WIDTH_DEF,
    parameter int SUM_WIDTH        = SUM_WIDTH_DEF,
    parameter int COUNT_WIDTH      = COUNT_WIDTH_DEF
)(
    input logic                        clk,
    input logic                        rst,
    connect_count_accumulator_if.slave bus
);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [COUNT_WIDTH-1:0] COUNT_ZERO = {COUNT_WIDTH{1'b0}};

    cca_state_e                  state_q, state_d;
    logic                        s1_valid_q, s1_valid_d;
    logic                        s1_armed_q, s1_armed_d;
    logic [EXTRA_DATA_WIDTH-1:0] s1_tag_q, s1_tag_d;
    logic [COUNT_WIDTH-1:0]      expected_q, expected_d;
    logic [COUNT_WIDTH-1:0]      received_q, received_d;
    logic [COUNT_WIDTH-1:0]      received_inc_s;
    logic [SUM_WIDTH-1:0]        sum_q, sum_d;
    logic [SUM_WIDTH-1:0]        sum_add_s;
    logic [EXTRA_DATA_WIDTH-1:0] checksum_q, checksum_d;
    logic                        stray_q, stray_d;
    logic                        busy_q, busy_d;
    logic                        valid_q, valid_d;
    logic                        start_take_s;
    logic                        accept_s;
    logic                        stray_hit_s;
    logic                        last_s;
`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
    logic                        carry_s;
    logic                        overflow_q, overflow_d;
`endif

    pow2_term_adder #(
        .SUM_WIDTH (SUM_WIDTH)
    ) u_term_adder (
        .clk     (clk),
        .rst     (rst),
        .load_i  (bus.done),
        .n_i     (bus.resultCount),
        .sum_i   (sum_q),
        .sum_o   (sum_add_s)
`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
        ,
        .carry_o (carry_s)
`endif
    );

    // Qualifiers: which start is honoured, which S1 entry is accepted or stray.
    always_comb begin
        start_take_s = (state_q == CCA_IDLE) && bus.start;
        accept_s     = s1_valid_q && s1_armed_q && (state_q == CCA_ACCUM);
        stray_hit_s  = s1_valid_q && !accept_s;
        if (&received_q) begin
            received_inc_s = received_q;
        end else begin
            received_inc_s = received_q + COUNT_ONE;
        end
        last_s = accept_s && (received_inc_s == expected_q);
    end

    // Batch FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            CCA_IDLE: begin
                if (bus.start) begin
                    if (bus.expectedCount == COUNT_ZERO) begin
                        state_d = CCA_FULL;
                    end else begin
                        state_d = CCA_ACCUM;
                    end
                end else begin
                    state_d = CCA_IDLE;
                end
            end
            CCA_ACCUM: begin
                if (last_s) begin
                    state_d = CCA_FULL;
                end else begin
                    state_d = CCA_ACCUM;
                end
            end
            CCA_FULL: begin
                if (bus.resultAck) begin
                    state_d = CCA_IDLE;
                end else begin
                    state_d = CCA_FULL;
                end
            end
            default: begin
                state_d = CCA_IDLE;
            end
        endcase
        busy_d  = (state_d != CCA_IDLE);
        valid_d = (state_d == CCA_FULL);
    end

    // Input stage capture: the armed bit remembers the state at capture time.
    always_comb begin
        s1_valid_d = bus.done;
        s1_armed_d = (state_q == CCA_ACCUM);
        if (bus.done) begin
            s1_tag_d = bus.extraDataIn;
        end else begin
            s1_tag_d = s1_tag_q;
        end
    end

    // Add stage and batch bookkeeping; start clears, accepted results accumulate.
    always_comb begin
        sum_d      = sum_q;
        checksum_d = checksum_q;
        received_d = received_q;
        expected_d = expected_q;
        if (start_take_s) begin
            sum_d      = {SUM_WIDTH{1'b0}};
            checksum_d = {EXTRA_DATA_WIDTH{1'b0}};
            received_d = COUNT_ZERO;
            expected_d = bus.expectedCount;
        end else if (accept_s) begin
            sum_d      = sum_add_s;
            checksum_d = checksum_q ^ s1_tag_q;
            received_d = received_inc_s;
        end else begin
            sum_d      = sum_q;
        end
        // A stray seen in the start cycle belongs to the new window, so set wins.
        stray_d = stray_q;
        if (stray_hit_s) begin
            stray_d = 1'b1;
        end else if (start_take_s) begin
            stray_d = 1'b0;
        end else begin
            stray_d = stray_q;
        end
    end

`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
    // Sticky overflow: any carry out while adding an accepted result.
    always_comb begin
        overflow_d = overflow_q;
        if (start_take_s) begin
            overflow_d = 1'b0;
        end else if (accept_s && carry_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

    // State, pipeline and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CCA_IDLE;
            s1_valid_q <= 1'b0;
            s1_armed_q <= 1'b0;
            s1_tag_q   <= {EXTRA_DATA_WIDTH{1'b0}};
            expected_q <= COUNT_ZERO;
            received_q <= COUNT_ZERO;
            sum_q      <= {SUM_WIDTH{1'b0}};
            checksum_q <= {EXTRA_DATA_WIDTH{1'b0}};
            stray_q    <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_armed_q <= s1_armed_d;
            s1_tag_q   <= s1_tag_d;
            expected_q <= expected_d;
            received_q <= received_d;
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
            stray_q    <= stray_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.busy            = busy_q;
    assign bus.resultValid     = valid_q;
    assign bus.resultSum       = sum_q;
    assign bus.resultChecksum  = checksum_q;
    assign bus.resultsReceived = received_q;
    assign bus.strayResult     = stray_q;

endmodule

// File: tb/tb_connect_count_accumulator.sv
// Self-checking bench for connect_count_accumulator: a table of batches run
// through a common task with a scoreboard queue, plus hand-written sequences
// for reset, stray results, ignored start/ack and mid-batch reset.
module tb_connect_count_accumulator;
    import connect_count_accumulator_pkg::*;

`ifdef CONNECT_ACCUM_OVERFLOW_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    connect_count_accumulator_if #(
        .EXTRA_DATA_WIDTH (14),
        .SUM_WIDTH        (64),
        .COUNT_WIDTH      (32)
    ) bus ();

    connect_count_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0]      exp_cnt;
        logic [2:0]       n_done;
        logic [3:0][5:0]  cnt;
        logic [3:0][13:0] tag;
        logic [63:0]      exp_sum;
        logic [13:0]      exp_chk;
        logic [31:0]      exp_rcv;
        logic             exp_stray;
        logic             exp_ovf;
        logic [3:0]       exp_wait;
    } vec_t;

    typedef struct packed {
        logic [63:0] sum;
        logic [13:0] chk;
        logic [31:0] rcv;
        logic        ovf;
        logic [3:0]  wait_cycles;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] ec, input logic [2:0] nd,
                                input logic [5:0] c0, input logic [5:0] c1,
                                input logic [5:0] c2, input logic [5:0] c3,
                                input logic [13:0] t0, input logic [13:0] t1,
                                input logic [13:0] t2, input logic [13:0] t3,
                                input logic [63:0] s, input logic [13:0] k,
                                input logic [31:0] r, input logic st,
                                input logic ov, input logic [3:0] w);
        vec_t v;
        v.exp_cnt = ec;   v.n_done = nd;
        v.cnt[0] = c0;    v.cnt[1] = c1;  v.cnt[2] = c2;  v.cnt[3] = c3;
        v.tag[0] = t0;    v.tag[1] = t1;  v.tag[2] = t2;  v.tag[3] = t3;
        v.exp_sum = s;    v.exp_chk = k;  v.exp_rcv = r;
        v.exp_stray = st; v.exp_ovf = ov; v.exp_wait = w;
        return v;
    endfunction

    // Wait (bounded) for resultValid; returns whether seen and cycles waited.
    task automatic wait_valid(output bit seen, output int waited);
        seen   = 1'b0;
        waited = 0;
        while (!seen && waited < 20) begin
            if (bus.resultValid) begin
                seen = 1'b1;
            end else begin
                tick();
                waited++;
            end
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_sum"},   bus.resultSum,       64'd0);
        check({name, "_chk"},   bus.resultChecksum,  64'd0);
        check({name, "_rcv"},   bus.resultsReceived, 64'd0);
        check({name, "_stray"}, bus.strayResult,     64'd0);
        check({name, "_ovf"},   bus.overflow,        64'd0);
        check({name, "_busy"},  bus.busy,            64'd0);
        check({name, "_valid"}, bus.resultValid,     64'd0);
    endtask

    // Run one batch from IDLE: start, back-to-back dones, await total, ack.
    task automatic run_batch(input vec_t v, input string name);
        sb_t e;
        bit  seen;
        int  waited;
        e.sum = v.exp_sum;  e.chk = v.exp_chk;  e.rcv = v.exp_rcv;
        e.ovf = v.exp_ovf;  e.wait_cycles = v.exp_wait;
        sb_q.push_back(e);
        bus.start         = 1'b1;
        bus.expectedCount = v.exp_cnt;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < int'(v.n_done); i++) begin
            bus.done        = 1'b1;
            bus.resultCount = v.cnt[i];
            bus.extraDataIn = v.tag[i];
            tick();
        end
        bus.done = 1'b0;
        wait_valid(seen, waited);
        check({name, "_valid_seen"}, seen, 64'd1);
        e = sb_q.pop_front();
        check({name, "_latency"}, waited, e.wait_cycles);
        check({name, "_sum"},  bus.resultSum,       e.sum);
        check({name, "_chk"},  bus.resultChecksum,  e.chk);
        check({name, "_rcv"},  bus.resultsReceived, e.rcv);
        check({name, "_ovf"},  bus.overflow,        e.ovf);
        check({name, "_busy"}, bus.busy,            64'd1);
        tick();
        tick();
        check({name, "_held_sum"},   bus.resultSum,   e.sum);
        check({name, "_held_valid"}, bus.resultValid, 64'd1);
        check({name, "_stray"},      bus.strayResult, v.exp_stray);
        bus.resultAck = 1'b1;
        tick();
        bus.resultAck = 1'b0;
        check({name, "_ack_busy"},  bus.busy,        64'd0);
        check({name, "_ack_valid"}, bus.resultValid, 64'd0);
    endtask

    initial begin
        bit seen;
        int waited;

        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.expectedCount = 32'd0;
        bus.done          = 1'b0;
        bus.resultCount   = 6'd0;
        bus.extraDataIn   = 14'd0;
        bus.resultAck     = 1'b0;

        vecs[0] = mk(32'd3, 3'd3, 6'd0, 6'd1, 6'd5, 6'd0, 14'h1, 14'h2, 14'h4, 14'h0,
                     64'd35, 14'h7, 32'd3, 1'b0, 1'b0, 4'd1);
        vecs[1] = mk(32'd2, 3'd3, 6'd2, 6'd3, 6'd4, 6'd0, 14'h10, 14'h20, 14'h40, 14'h0,
                     64'd12, 14'h30, 32'd2, 1'b1, 1'b0, 4'd0);
        vecs[2] = mk(32'd4, 3'd4, 6'd63, 6'd0, 6'd10, 6'd10, 14'h3FFF, 14'h1, 14'h100, 14'h100,
                     64'h8000_0000_0000_0801, 14'h3FFE, 32'd4, 1'b0, 1'b0, 4'd1);
        vecs[3] = mk(32'd2, 3'd2, 6'd63, 6'd63, 6'd0, 6'd0, 14'h5, 14'h6, 14'h0, 14'h0,
                     64'd0, 14'h3, 32'd2, 1'b0, OVF_EXP, 4'd1);
        vecs[4] = mk(32'd1, 3'd1, 6'd63, 6'd0, 6'd0, 6'd0, 14'h2AAA, 14'h0, 14'h0, 14'h0,
                     64'h8000_0000_0000_0000, 14'h2AAA, 32'd1, 1'b0, 1'b0, 4'd1);
        vecs[5] = mk(32'd0, 3'd0, 6'd0, 6'd0, 6'd0, 6'd0, 14'h0, 14'h0, 14'h0, 14'h0,
                     64'd0, 14'h0, 32'd0, 1'b0, 1'b0, 4'd0);

        @(negedge clk);
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        // Stray result while idle, then a batch that clears it and ignores it.
        bus.done        = 1'b1;
        bus.resultCount = 6'd20;
        bus.extraDataIn = 14'h55;
        tick();
        bus.done = 1'b0;
        tick();
        check("idle_stray_set", bus.strayResult, 64'd1);
        check("idle_stray_nosum", bus.resultSum, 64'd0);
        run_batch(mk(32'd1, 3'd1, 6'd3, 6'd0, 6'd0, 6'd0, 14'h9, 14'h0, 14'h0, 14'h0,
                     64'd8, 14'h9, 32'd1, 1'b0, 1'b0, 4'd1), "stray_clear");

        // Table of batches.
        for (int i = 0; i < 6; i++) begin
            run_batch(vecs[i], $sformatf("vec%0d", i));
        end

        // done coincident with start is stray; start while ACCUM is ignored.
        bus.start = 1'b1;  bus.expectedCount = 32'd2;
        bus.done  = 1'b1;  bus.resultCount = 6'd4;  bus.extraDataIn = 14'h1;
        tick();
        bus.start = 1'b0;
        bus.resultCount = 6'd2;  bus.extraDataIn = 14'h2;
        tick();
        bus.start = 1'b1;  bus.expectedCount = 32'd7;
        bus.resultCount = 6'd3;  bus.extraDataIn = 14'h4;
        tick();
        bus.start = 1'b0;
        bus.done  = 1'b0;
        wait_valid(seen, waited);
        check("coinc_valid_seen", seen, 64'd1);
        check("coinc_latency", waited, 64'd1);
        check("coinc_sum", bus.resultSum, 64'd12);
        check("coinc_chk", bus.resultChecksum, 64'h6);
        check("coinc_rcv", bus.resultsReceived, 64'd2);
        check("coinc_stray", bus.strayResult, 64'd1);

        // Ack and start together in FULL: ack taken, start (count 0) ignored.
        bus.resultAck = 1'b1;
        bus.start     = 1'b1;
        bus.expectedCount = 32'd0;
        tick();
        bus.resultAck = 1'b0;
        bus.start     = 1'b0;
        check("ackstart_busy", bus.busy, 64'd0);
        check("ackstart_valid", bus.resultValid, 64'd0);
        tick();
        check("ackstart_valid_later", bus.resultValid, 64'd0);
        check("ackstart_sum_kept", bus.resultSum, 64'd12);

        // Reset mid-batch after one of four results.
        bus.start = 1'b1;  bus.expectedCount = 32'd4;
        tick();
        bus.start = 1'b0;
        bus.done  = 1'b1;  bus.resultCount = 6'd5;  bus.extraDataIn = 14'h3;
        tick();
        bus.done = 1'b0;
        tick();
        check("midrst_partial_sum", bus.resultSum, 64'd32);
        check("midrst_partial_rcv", bus.resultsReceived, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("midrst");
        run_batch(vecs[4], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
